snn_cfg_arbiter: RTL and testbench

- Owns the single configuration write port of `snn_layer` (`cfg_we`, `cfg_sel_delay`, `cfg_addr`, `cfg_wdata`, `cfg_delay`).
- Shares that port between two requesters:
  - a host port that writes absolute weights or delays;
  - a plasticity port that sends signed weight deltas.
- Keeps a shadow copy of all synaptic weights so it can apply deltas as read-modify-write with saturation.
- Supports a freeze window that blocks writes while inference must see stable weights.

---
 rtl/lif_pkg.sv | 35 +++
 rtl/snn_cfg_arbiter_if.sv | 43 ++++
 rtl/rr_arb2.sv | 30 +++
 rtl/snn_cfg_arbiter.sv | 107 ++++++++++
 tb/tb_snn_cfg_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lif_pkg.sv
// Shared fixed-point types and helpers for the SNN layer and its config path.
// Weights are signed Q7.8; FX() converts a real constant at elaboration time.
package lif_pkg;
  localparam int W = 16;
  localparam int FRAC = 8;
  localparam int CFG_ADDR_W = 16;

  typedef logic signed [W-1:0] w_t;

  typedef enum logic {
    RR_HOST = 1'b0,
    RR_PL   = 1'b1
  } rr_t;

  typedef struct packed {
    logic                  sel_delay;
    logic [CFG_ADDR_W-1:0] addr;
    w_t                    wdata;
    logic [7:0]            delay;
  } cfg_req_t;

  function automatic w_t FX(real x);
    real s;
    s = x * (2.0 ** FRAC);
    return w_t'($rtoi(s >= 0.0 ? s + 0.5 : s - 0.5));
  endfunction

  function automatic w_t sat_add(w_t a, w_t b, w_t lo, w_t hi);
    logic signed [W:0] s;
    s = $signed({a[W-1], a}) + $signed({b[W-1], b});
    if (s > $signed({hi[W-1], hi})) return hi;
    if (s < $signed({lo[W-1], lo})) return lo;
    return s[W-1:0];
  endfunction
endpackage

// File: rtl/snn_cfg_arbiter_if.sv
// Host / plasticity request ports and the layer config write port.
// Master drives requests and sees the config port; slave is the arbiter.
interface snn_cfg_arbiter_if
  import lif_pkg::*;
#(
  parameter int ADDR_W = 1
);
  logic              host_valid;
  logic              host_ready;
  logic              host_sel_delay;
  logic [ADDR_W-1:0] host_addr;
  w_t                host_wdata;
  logic [7:0]        host_delay;

  logic              pl_valid;
  logic              pl_ready;
  logic [ADDR_W-1:0] pl_addr;
  w_t                pl_delta;

  logic              cfg_we;
  logic              cfg_sel_delay;
  logic [ADDR_W-1:0] cfg_addr;
  w_t                cfg_wdata;
  logic [7:0]        cfg_delay;

  modport master (
    output host_valid, host_sel_delay, host_addr,
    output host_wdata, host_delay,
    output pl_valid, pl_addr, pl_delta,
    input  host_ready, pl_ready,
    input  cfg_we, cfg_sel_delay, cfg_addr,
    input  cfg_wdata, cfg_delay
  );

  modport slave (
    input  host_valid, host_sel_delay, host_addr,
    input  host_wdata, host_delay,
    input  pl_valid, pl_addr, pl_delta,
    output host_ready, pl_ready,
    output cfg_we, cfg_sel_delay, cfg_addr,
    output cfg_wdata, cfg_delay
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; rr_last remembers the last granted side.
// Reset favours the host on the first tie.
module rr_arb2
  import lif_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic freeze,
  input  logic host_valid,
  input  logic pl_valid,
  output logic host_ready,
  output logic pl_ready
);
  rr_t rr_last;

  assign host_ready = !freeze && host_valid &&
                      (!pl_valid || rr_last == RR_PL);
  assign pl_ready   = !freeze && pl_valid &&
                      (!host_valid || rr_last == RR_HOST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last <= RR_PL;
    end else if (host_ready) begin
      rr_last <= RR_HOST;
    end else if (pl_ready) begin
      rr_last <= RR_PL;
    end
  end
endmodule

// File: rtl/snn_cfg_arbiter.sv
// Arbitrates host and plasticity writes onto the layer config port,
// keeping a weight shadow so plasticity deltas saturate correctly.
module snn_cfg_arbiter
  import lif_pkg::*;
#(
  parameter int NUM_INPUTS  = 2,
  parameter int NUM_NEURONS = 2,
  parameter int MAX_DELAY   = 8,
  parameter w_t W_INIT [NUM_NEURONS][NUM_INPUTS] = '{default: '0},
  parameter w_t W_MIN = FX(-1.0),
  parameter w_t W_MAX = FX(1.0)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               err_clr,
  output logic [15:0]        wr_count,
  output logic               err,
  snn_cfg_arbiter_if.slave   bus
);
  localparam int NSYN = NUM_NEURONS * NUM_INPUTS;
  localparam int ADDR_W = (NSYN > 1) ? $clog2(NSYN) : 1;

  logic host_ready;
  logic pl_ready;

  rr_arb2 u_arb (
    .clk        (clk),
    .rst        (rst),
    .freeze     (freeze),
    .host_valid (bus.host_valid),
    .pl_valid   (bus.pl_valid),
    .host_ready (host_ready),
    .pl_ready   (pl_ready)
  );

  assign bus.host_ready = host_ready;
  assign bus.pl_ready   = pl_ready;

  w_t shadow [NSYN];

  logic              accept;
  logic              oob;
  logic              bad_delay;
  logic              issue;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] idx;
  cfg_req_t          req;

  always_comb begin
    accept    = host_ready || pl_ready;
    addr      = host_ready ? bus.host_addr : bus.pl_addr;
    oob       = int'(addr) >= NSYN;
    idx       = oob ? '0 : addr;
    bad_delay = host_ready && bus.host_sel_delay &&
                (bus.host_delay >= 8'(MAX_DELAY));
    issue     = accept && !oob;
    // Fields a request does not carry keep the port's current value
    req.sel_delay = host_ready && bus.host_sel_delay;
    req.addr      = CFG_ADDR_W'(addr);
    req.wdata     = bus.cfg_wdata;
    req.delay     = bus.cfg_delay;
    if (host_ready) begin
      if (bus.host_sel_delay) begin
        req.delay = bad_delay ? 8'(MAX_DELAY - 1) : bus.host_delay;
      end else begin
        req.wdata = bus.host_wdata;
      end
    end else begin
      req.wdata = sat_add(shadow[idx], bus.pl_delta, W_MIN, W_MAX);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.cfg_we        <= 1'b0;
      bus.cfg_sel_delay <= 1'b0;
      bus.cfg_addr      <= '0;
      bus.cfg_wdata     <= '0;
      bus.cfg_delay     <= '0;
      wr_count          <= '0;
      err               <= 1'b0;
      for (int n = 0; n < NUM_NEURONS; n++) begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
          shadow[n*NUM_INPUTS+i] <= W_INIT[n][i];
        end
      end
    end else begin
      bus.cfg_we <= issue;
      if (issue) begin
        bus.cfg_sel_delay <= req.sel_delay;
        bus.cfg_addr      <= req.addr[ADDR_W-1:0];
        bus.cfg_wdata     <= req.wdata;
        bus.cfg_delay     <= req.delay;
        wr_count          <= wr_count + 16'd1;
        if (!req.sel_delay) begin
          shadow[idx] <= req.wdata;
        end
      end
      if (accept && (oob || bad_delay)) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_snn_cfg_arbiter.sv
// Scoreboard bench for snn_cfg_arbiter: a reference model predicts grants,
// shadow contents and errors; expected writes queue until the strobe.
module tb_snn_cfg_arbiter;
  import lif_pkg::*;

  localparam int NI = 2;
  localparam int NN = 3;
  localparam int NS = NI * NN;
  localparam int AW = 3;
  localparam int MD = 8;
  localparam w_t WI [NN][NI] = '{
    '{FX(0.30), FX(0.0)},
    '{FX(0.0),  FX(0.0)},
    '{FX(0.0),  FX(0.0)}
  };

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        err_clr;
  logic [15:0] wr_count;
  logic        err;

  snn_cfg_arbiter_if #(.ADDR_W(AW)) bus ();

  snn_cfg_arbiter #(
    .NUM_INPUTS  (NI),
    .NUM_NEURONS (NN),
    .MAX_DELAY   (MD),
    .W_INIT      (WI)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .freeze   (freeze),
    .err_clr  (err_clr),
    .wr_count (wr_count),
    .err      (err),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic sel;
    int   addr;
    int   val;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   sh [NS];
  int   rr_m;
  logic err_m;
  logic [15:0] wr_m;

  function automatic int sat(int s);
    if (s > int'(FX(1.0))) return int'(FX(1.0));
    if (s < int'(FX(-1.0))) return int'(FX(-1.0));
    return s;
  endfunction

  task automatic reset_model();
    for (int n = 0; n < NN; n++)
      for (int i = 0; i < NI; i++)
        sh[n*NI+i] = int'(WI[n][i]);
    rr_m  = 1;
    err_m = 1'b0;
    wr_m  = '0;
    q.delete();
  endtask

  task automatic set_host(logic v, logic sel, int a, w_t wd, int d);
    bus.host_valid     = v;
    bus.host_sel_delay = sel;
    bus.host_addr      = AW'(a);
    bus.host_wdata     = wd;
    bus.host_delay     = 8'(d);
  endtask

  task automatic set_pl(logic v, int a, w_t dl);
    bus.pl_valid = v;
    bus.pl_addr  = AW'(a);
    bus.pl_delta = dl;
  endtask

  // Called at a negedge with inputs already applied; returns at next negedge
  task automatic step();
    logic hr, pr, nerr;
    int   a;
    exp_t e;
    #1;
    hr = !freeze && bus.host_valid && (!bus.pl_valid || rr_m == 1);
    pr = !freeze && bus.pl_valid && (!bus.host_valid || rr_m == 0);
    total++;
    if (bus.host_ready !== hr || bus.pl_ready !== pr) begin
      bad++;
      $display("FAIL ready: got h=%0b p=%0b want h=%0b p=%0b",
               bus.host_ready, bus.pl_ready, hr, pr);
    end
    nerr = 1'b0;
    if (hr) begin
      rr_m = 0;
      a = int'(bus.host_addr);
      if (a >= NS) begin
        nerr = 1'b1;
      end else begin
        e.addr = a;
        e.sel  = bus.host_sel_delay;
        if (bus.host_sel_delay) begin
          e.val = int'(bus.host_delay);
          if (e.val >= MD) begin
            e.val = MD - 1;
            nerr = 1'b1;
          end
        end else begin
          e.val = int'(bus.host_wdata);
          sh[a] = e.val;
        end
        q.push_back(e);
        wr_m++;
      end
    end else if (pr) begin
      rr_m = 1;
      a = int'(bus.pl_addr);
      if (a >= NS) begin
        nerr = 1'b1;
      end else begin
        e.addr = a;
        e.sel  = 1'b0;
        e.val  = sat(sh[a] + int'(bus.pl_delta));
        sh[a]  = e.val;
        q.push_back(e);
        wr_m++;
      end
    end
    if (nerr) err_m = 1'b1;
    else if (err_clr) err_m = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (bus.cfg_we !== (q.size() != 0)) begin
      bad++;
      $display("FAIL cfg_we: got %0b want %0b", bus.cfg_we, q.size() != 0);
    end
    if (bus.cfg_we === 1'b1 && q.size() != 0) begin
      e = q.pop_front();
      total++;
      if (bus.cfg_sel_delay !== e.sel || int'(bus.cfg_addr) != e.addr ||
          (e.sel ? int'(bus.cfg_delay) : int'(bus.cfg_wdata)) != e.val) begin
        bad++;
        $display("FAIL payload: got sel=%0b addr=%0d wd=%0d dly=%0d want sel=%0b addr=%0d val=%0d",
                 bus.cfg_sel_delay, bus.cfg_addr, bus.cfg_wdata,
                 bus.cfg_delay, e.sel, e.addr, e.val);
      end
    end
    q.delete();
    total++;
    if (wr_count !== wr_m || err !== err_m) begin
      bad++;
      $display("FAIL status: got wr=%0d err=%0b want wr=%0d err=%0b",
               wr_count, err, wr_m, err_m);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    set_host(1'b0, 1'b0, 0, '0, 0);
    set_pl(1'b0, 0, '0);
    step();
  endtask

  task automatic do_reset();
    set_host(1'b0, 1'b0, 0, '0, 0);
    set_pl(1'b0, 0, '0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    reset_model();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    freeze = 1'b0;
    err_clr = 1'b0;
    set_host(1'b0, 1'b0, 0, '0, 0);
    set_pl(1'b0, 0, '0);
    repeat (2) @(negedge clk);
    total++;
    if (bus.cfg_we !== 1'b0 || wr_count !== 16'd0 || err !== 1'b0 ||
        bus.cfg_addr !== '0 || bus.cfg_wdata !== '0) begin
      bad++;
      $display("FAIL reset: got we=%0b wr=%0d err=%0b addr=%0d wd=%0d want 0",
               bus.cfg_we, wr_count, err, bus.cfg_addr, bus.cfg_wdata);
    end
    rst = 1'b0;
    reset_model();
  endtask

  task automatic test_host_write();
    set_host(1'b1, 1'b0, 2, FX(0.50), 0);
    step();
    total++;
    if (bus.cfg_wdata !== FX(0.50) || wr_count !== 16'd1) begin
      bad++;
      $display("FAIL host_write: got wd=%0d wr=%0d want %0d 1",
               bus.cfg_wdata, wr_count, FX(0.50));
    end
    idle();
    total++;
    if (bus.cfg_wdata !== FX(0.50) || bus.cfg_addr !== 3'd2) begin
      bad++;
      $display("FAIL hold: got wd=%0d addr=%0d want %0d 2",
               bus.cfg_wdata, bus.cfg_addr, FX(0.50));
    end
  endtask

  task automatic test_pl_b2b();
    set_pl(1'b1, 0, FX(0.25));
    step();
    total++;
    if (bus.cfg_wdata !== FX(0.55)) begin
      bad++;
      $display("FAIL pl_first: got %0d want %0d", bus.cfg_wdata, FX(0.55));
    end
    step();
    total++;
    if (bus.cfg_wdata !== FX(0.80)) begin
      bad++;
      $display("FAIL pl_second: got %0d want %0d", bus.cfg_wdata, FX(0.80));
    end
    idle();
  endtask

  task automatic test_clamp();
    set_host(1'b1, 1'b0, 1, FX(0.90), 0);
    step();
    set_host(1'b0, 1'b0, 0, '0, 0);
    set_pl(1'b1, 1, FX(0.50));
    step();
    total++;
    if (bus.cfg_wdata !== FX(1.0) || err !== 1'b0) begin
      bad++;
      $display("FAIL clamp_hi: got wd=%0d err=%0b want %0d 0",
               bus.cfg_wdata, err, FX(1.0));
    end
    set_pl(1'b1, 1, FX(-3.0));
    step();
    total++;
    if (bus.cfg_wdata !== FX(-1.0)) begin
      bad++;
      $display("FAIL clamp_lo: got %0d want %0d", bus.cfg_wdata, FX(-1.0));
    end
    idle();
  endtask

  task automatic test_round_robin();
    do_reset();
    set_host(1'b1, 1'b0, 3, FX(0.125), 0);
    set_pl(1'b1, 4, FX(0.0625));
    repeat (4) step();
    idle();
    total++;
    if (wr_count !== 16'd4) begin
      bad++;
      $display("FAIL rr_count: got %0d want 4", wr_count);
    end
  endtask

  task automatic test_errors();
    set_host(1'b1, 1'b1, 0, '0, 12);
    step();
    total++;
    if (bus.cfg_delay !== 8'd7 || err !== 1'b1) begin
      bad++;
      $display("FAIL delay_clip: got dly=%0d err=%0b want 7 1",
               bus.cfg_delay, err);
    end
    set_host(1'b1, 1'b1, 1, '0, 7);
    step();
    err_clr = 1'b1;
    idle();
    err_clr = 1'b0;
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL err_clr: got %0b want 0", err);
    end
    set_host(1'b1, 1'b0, 6, FX(0.5), 0);
    step();
    set_host(1'b0, 1'b0, 0, '0, 0);
    err_clr = 1'b1;
    set_pl(1'b1, 7, FX(0.5));
    step();
    total++;
    if (err !== 1'b1 || bus.cfg_we !== 1'b0) begin
      bad++;
      $display("FAIL err_wins: got err=%0b we=%0b want 1 0", err, bus.cfg_we);
    end
    idle();
    err_clr = 1'b0;
    idle();
  endtask

  task automatic test_freeze();
    freeze = 1'b1;
    set_host(1'b1, 1'b0, 5, FX(-0.5), 0);
    repeat (3) step();
    freeze = 1'b0;
    step();
    set_host(1'b1, 1'b0, 4, FX(0.75), 0);
    step();
    freeze = 1'b1;
    step();
    freeze = 1'b0;
    idle();
  endtask

  task automatic test_reset_mid();
    set_host(1'b1, 1'b0, 0, FX(0.75), 0);
    @(posedge clk);
    #1;
    total++;
    if (bus.cfg_we !== 1'b1) begin
      bad++;
      $display("FAIL mid_strobe: got %0b want 1", bus.cfg_we);
    end
    rst = 1'b1;
    #1;
    total++;
    if (bus.cfg_we !== 1'b0 || wr_count !== 16'd0) begin
      bad++;
      $display("FAIL mid_reset: got we=%0b wr=%0d want 0 0",
               bus.cfg_we, wr_count);
    end
    set_host(1'b0, 1'b0, 0, '0, 0);
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    set_pl(1'b1, 0, FX(0.0));
    step();
    total++;
    if (bus.cfg_wdata !== FX(0.30)) begin
      bad++;
      $display("FAIL shadow_reset: got %0d want %0d", bus.cfg_wdata, FX(0.30));
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_host_write();
    test_pl_b2b();
    test_clamp();
    test_round_robin();
    test_errors();
    test_freeze();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
